// File: rtl/bitbang_resp_pkg.sv
// Shared types and defaults for the bit-bang word-link responder.
package bitbang_resp_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_e;

    localparam logic [15:0] DEF_SYNC = 16'hB38F;
    localparam logic [15:0] DEF_FILL = 16'h0000;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bitbang_shift.sv
// W-bit MSB-first shift register with parallel load (load wins over shift).
module bitbang_shift #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         shift_i,
    input  logic         sin_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= data_i;
        end else if (shift_i) begin
            q_q <= {q_q[W-2:0], sin_i};
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/bitbang_resp.sv
// Far-end responder: hunts for SYNC, deserialises FRAME words, serialises replies.
// Optional frame/drop counters enabled by defining BITBANG_RESP_STATS_EN.
module bitbang_resp
    import bitbang_resp_pkg::*;
#(
    parameter int unsigned   W     = 16,
    parameter logic [W-1:0]  SYNC  = W'(DEF_SYNC),
    parameter int unsigned   FRAME = 8,
    parameter logic [W-1:0]  FILL  = W'(DEF_FILL)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx,
    output logic         tx,
    input  logic [W-1:0] in,
    output logic         get,
    input  logic         empty,
    output logic [W-1:0] out,
    output logic         put,
    input  logic         full,
    output logic         in_frame,
    output logic         overrun
`ifdef BITBANG_RESP_STATS_EN
    ,
    output logic [15:0]  frames,
    output logic [15:0]  drops
`endif
);

    localparam int unsigned CW = cnt_width(W);

    state_e        state_q, state_d;
    logic [W-1:0]  window_q, window_d, win_next;
    logic [CW-1:0] bitcnt_q, bitcnt_d;
    logic [7:0]    word_q, word_d;
    logic          wvalid_q, wvalid_d;
    logic [W-1:0]  out_q, out_d;
    logic          overrun_q, overrun_d;
    logic [W-1:0]  slot_q, slot_d;
    logic          slot_full_q, slot_full_d;
    logic          get_q, get_d;
    logic          pend_q, pend_d;
    logic          tx_load, frame_done, drop;
    logic [W-1:0]  load_word, rx_q, tx_q;
    logic          unused_bits;

    always_comb begin
        state_d    = state_q;
        window_d   = window_q;
        bitcnt_d   = bitcnt_q;
        word_d     = word_q;
        out_d      = out_q;
        wvalid_d   = 1'b0;
        tx_load    = 1'b0;
        frame_done = 1'b0;
        win_next   = {window_q[W-2:0], rx};
        case (state_q)
            HUNT: begin
                window_d = win_next;
                if (win_next == SYNC) begin
                    state_d  = DATA;
                    bitcnt_d = CW'(W);
                    word_d   = '0;
                    tx_load  = 1'b1;
                end
            end
            DATA: begin
                bitcnt_d = bitcnt_q - 1'b1;
                if (bitcnt_q == CW'(1)) begin
                    wvalid_d = 1'b1;
                    out_d    = {rx_q[W-2:0], rx};
                    if (word_q == 8'(FRAME - 1)) begin
                        state_d    = HUNT;
                        window_d   = '0;
                        frame_done = 1'b1;
                    end else begin
                        bitcnt_d = CW'(W);
                        word_d   = word_q + 8'd1;
                        tx_load  = 1'b1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        drop      = wvalid_q & full;
        overrun_d = overrun_q | drop;

        // A load and a capture may coincide: the load takes the old slot, the capture refills it.
        load_word   = slot_full_q ? slot_q : FILL;
        slot_d      = pend_q ? in : slot_q;
        slot_full_d = pend_q | (slot_full_q & ~tx_load);
        get_d       = ~slot_full_q & ~empty & ~get_q & ~pend_q;
        pend_d      = get_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            window_q    <= '0;
            bitcnt_q    <= '0;
            word_q      <= '0;
            wvalid_q    <= 1'b0;
            out_q       <= '0;
            overrun_q   <= 1'b0;
            slot_q      <= '0;
            slot_full_q <= 1'b0;
            get_q       <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            window_q    <= window_d;
            bitcnt_q    <= bitcnt_d;
            word_q      <= word_d;
            wvalid_q    <= wvalid_d;
            out_q       <= out_d;
            overrun_q   <= overrun_d;
            slot_q      <= slot_d;
            slot_full_q <= slot_full_d;
            get_q       <= get_d;
            pend_q      <= pend_d;
        end
    end

    bitbang_shift #(.W(W)) u_rx_shift (
        .clk_i   (clock),
        .rst_ni  (reset),
        .load_i  (1'b0),
        .data_i  ('0),
        .shift_i (state_q == DATA),
        .sin_i   (rx),
        .q_o     (rx_q)
    );

    bitbang_shift #(.W(W)) u_tx_shift (
        .clk_i   (clock),
        .rst_ni  (reset),
        .load_i  (tx_load),
        .data_i  (load_word),
        .shift_i (state_q == DATA),
        .sin_i   (1'b0),
        .q_o     (tx_q)
    );

    assign unused_bits = ^{rx_q[W-1], tx_q[W-2:0]};

    assign tx       = (state_q == DATA) ? tx_q[W-1] : 1'b1;
    assign put      = wvalid_q & ~full;
    assign out      = out_q;
    assign get      = get_q;
    assign in_frame = (state_q == DATA);
    assign overrun  = overrun_q;

`ifdef BITBANG_RESP_STATS_EN
    logic [15:0] frames_q, drops_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frames_q <= '0;
            drops_q  <= '0;
        end else begin
            if (frame_done && frames_q != '1) frames_q <= frames_q + 16'd1;
            if (drop && drops_q != '1)        drops_q  <= drops_q + 16'd1;
        end
    end

    assign frames = frames_q;
    assign drops  = drops_q;
`else
    logic unused_stats;
    assign unused_stats = frame_done;
`endif

endmodule
